// File: rtl/inv_key_expand.sv
// Reverse AES-128 key schedule: walks from the round-10 key back to round 0, one round key per clock.
// Optional INV_KEY_STORE_EN adds an 11-entry round-key register file with a combinational read port.

module inv_key_expand_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign s = SBOX[a];
endmodule

module inv_key_expand #(
    parameter int unsigned NR        = 10,
    parameter logic [7:0]  RCON_LAST = 8'h36
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [0:127] key_in,
    output logic         busy,
    output logic         rk_valid,
    output logic [0:127] rk_out,
    output logic [3:0]   round_idx,
    output logic         done
`ifdef INV_KEY_STORE_EN
    ,
    input  logic [3:0]   rd_addr,
    output logic [0:127] rd_key
`endif
);
    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t       state, next_state;
    logic [0:127] cur_key;
    logic [3:0]   idx;
    logic [7:0]   rcon;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  p0, p1, p2, p3;
    logic [31:0]  rot, sub, g;
    logic [0:127] prev_key;
    logic [7:0]   rcon_prev;

    // Undo forward expansion: the last three words are pairwise XORs, then word 0 uses g() of the recovered word 3.
    assign w0 = cur_key[0:31];
    assign w1 = cur_key[32:63];
    assign w2 = cur_key[64:95];
    assign w3 = cur_key[96:127];

    assign p3 = w3 ^ w2;
    assign p2 = w2 ^ w1;
    assign p1 = w1 ^ w0;

    assign rot = {p3[23:0], p3[31:24]};

    inv_key_expand_sbox u_sbox0 (.a(rot[31:24]), .s(sub[31:24]));
    inv_key_expand_sbox u_sbox1 (.a(rot[23:16]), .s(sub[23:16]));
    inv_key_expand_sbox u_sbox2 (.a(rot[15:8]),  .s(sub[15:8]));
    inv_key_expand_sbox u_sbox3 (.a(rot[7:0]),   .s(sub[7:0]));

    assign g        = sub ^ {rcon, 24'h000000};
    assign p0       = w0 ^ g;
    assign prev_key = {p0, p1, p2, p3};

    // Inverse of xtime over the Rcon chain: 0x1b came from 0x80, everything else is a plain halving.
    assign rcon_prev = (rcon == 8'h1b) ? 8'h80 : {1'b0, rcon[7:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = RUN;
            RUN:  if (idx == 4'd0) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        rk_valid = 1'b0;
        done     = 1'b0;
        if (state == RUN) begin
            busy     = 1'b1;
            rk_valid = 1'b1;
            done     = (idx == 4'd0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_key <= '0;
            idx     <= '0;
            rcon    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cur_key <= key_in;
                        idx     <= 4'(NR);
                        rcon    <= RCON_LAST;
                    end
                end
                RUN: begin
                    if (idx != 4'd0) begin
                        cur_key <= prev_key;
                        idx     <= idx - 4'd1;
                        rcon    <= rcon_prev;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rk_out    = cur_key;
    assign round_idx = idx;

`ifdef INV_KEY_STORE_EN
    logic [0:127] key_store [0:10];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i <= 10; i++) begin
                key_store[i] <= '0;
            end
        end else if (rk_valid) begin
            key_store[idx] <= cur_key;
        end
    end

    assign rd_key = (rd_addr <= 4'd10) ? key_store[rd_addr] : '0;
`endif
endmodule

// File: tb/tb_inv_key_expand.sv
// Randomized self-checking bench for inv_key_expand against a word-level key schedule model.
// Store-port checks are compiled in when INV_KEY_STORE_EN is defined.

module tb_inv_key_expand;
    localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] FIPS_K9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic         busy, rk_valid, done;
    logic [127:0] rk_out;
    logic [3:0]   round_idx;
`ifdef INV_KEY_STORE_EN
    logic [3:0]   rd_addr = '0;
    logic [127:0] rd_key;
`endif

    int unsigned  n_vec = 0;
    int unsigned  n_err = 0;
    logic [7:0]   sbox_ref [256];
    logic [7:0]   rcon_ref [11];
    logic [127:0] exp_rk [11];

    inv_key_expand #(.NR(10), .RCON_LAST(8'h36)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .key_in    (key_in),
        .busy      (busy),
        .rk_valid  (rk_valid),
        .rk_out    (rk_out),
        .round_idx (round_idx),
        .done      (done)
`ifdef INV_KEY_STORE_EN
        ,
        .rd_addr   (rd_addr),
        .rd_key    (rd_key)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t = {x, x};
        return t[15-n -: 8];
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    task automatic build_tables();
        logic [7:0] inv, r;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox_ref[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        r = 8'h01;
        rcon_ref[0] = 8'h00;
        for (int j = 1; j <= 10; j++) begin
            rcon_ref[j] = r;
            r = gmul(r, 8'h02);
        end
    endtask

    // Solve the forward recurrence w[i] = w[i-4] ^ t(w[i-1]) for w[i-4], from w[40..43] down to w[0].
    task automatic model_schedule(input logic [127:0] k10);
        logic [31:0] w [44];
        logic [31:0] t, rw;
        for (int j = 0; j < 4; j++) w[40+j] = k10[127-32*j -: 32];
        for (int i = 43; i >= 4; i--) begin
            if (i % 4 == 0) begin
                rw = {w[i-1][23:0], w[i-1][31:24]};
                t  = {sbox_ref[rw[31:24]], sbox_ref[rw[23:16]], sbox_ref[rw[15:8]], sbox_ref[rw[7:0]]}
                     ^ {rcon_ref[i/4], 24'h0};
            end else begin
                t = w[i-1];
            end
            w[i-4] = w[i] ^ t;
        end
        for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Starts at the current negedge; returns at the negedge of the first IDLE cycle.
    task automatic run(input logic [127:0] key, input bit poke5, input bit poke_done);
        model_schedule(key);
        key_in = key;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        key_in = rand_key();
        for (int k = 0; k <= 10; k++) begin
            check($sformatf("rk_valid@%0d", k), 128'(rk_valid), 128'(1));
            check($sformatf("busy@%0d", k), 128'(busy), 128'(1));
            check($sformatf("round_idx@%0d", k), 128'(round_idx), 128'(10 - k));
            check($sformatf("rk_out@r%0d", 10 - k), rk_out, exp_rk[10 - k]);
            check($sformatf("done@%0d", k), 128'(done), 128'(k == 10));
            if (key == FIPS_K10) begin
                if (k == 0)  check("fips_r10", rk_out, FIPS_K10);
                if (k == 1)  check("fips_r9",  rk_out, FIPS_K9);
                if (k == 9)  check("fips_r1",  rk_out, FIPS_K1);
                if (k == 10) check("fips_r0",  rk_out, FIPS_K0);
            end
            if ((poke5 && k == 5) || (poke_done && k == 10)) begin
                start  = 1'b1;
                key_in = rand_key();
            end
            @(negedge clk);
            start = 1'b0;
        end
        check("idle_rk_valid", 128'(rk_valid), 128'(0));
        check("idle_busy", 128'(busy), 128'(0));
        check("idle_done", 128'(done), 128'(0));
        check("idle_rk_hold", rk_out, exp_rk[0]);
        check("idle_round_idx", 128'(round_idx), 128'(0));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 128'(busy), 128'(0));
        check({tag, "_rk_valid"}, 128'(rk_valid), 128'(0));
        check({tag, "_done"}, 128'(done), 128'(0));
        check({tag, "_rk_out"}, rk_out, 128'(0));
        check({tag, "_round_idx"}, 128'(round_idx), 128'(0));
    endtask

    initial begin
        build_tables();
        #1;
        check_zero("reset");
`ifdef INV_KEY_STORE_EN
        rd_addr = 4'd10;
        #1 check("store_reset", rd_key, 128'(0));
`endif
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_zero("post_reset_idle");

        run(FIPS_K10, 1'b0, 1'b0);
`ifdef INV_KEY_STORE_EN
        rd_addr = 4'd0;
        #1 check("store_r0", rd_key, FIPS_K0);
        rd_addr = 4'd10;
        #1 check("store_r10", rd_key, FIPS_K10);
        rd_addr = 4'd1;
        #1 check("store_r1", rd_key, FIPS_K1);
        rd_addr = 4'd12;
        #1 check("store_addr12", rd_key, 128'(0));
        @(negedge clk);
`endif

        // start while busy (round 5) and in the done cycle are both ignored; next run starts back-to-back
        run(FIPS_K10, 1'b1, 1'b1);
        run(rand_key(), 1'b0, 1'b0);

        // asynchronous reset between edges while round_idx==6
        model_schedule(FIPS_K10);
        key_in = FIPS_K10;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        for (int k = 0; k < 4; k++) @(negedge clk);
        check("pre_abort_round_idx", 128'(round_idx), 128'(6));
        check("pre_abort_rk_out", rk_out, exp_rk[6]);
        #2 reset = 1'b1;
        #1 check_zero("abort");
`ifdef INV_KEY_STORE_EN
        rd_addr = 4'd10;
        #0 check("store_abort", rd_key, 128'(0));
`endif
        @(negedge clk);
        check_zero("abort_held");
        reset = 1'b0;
        @(negedge clk);
        check_zero("abort_idle");
        run(FIPS_K10, 1'b0, 1'b0);

        for (int n = 0; n < 8; n++) begin
            logic [127:0] k;
            k = rand_key();
            run(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
`ifdef INV_KEY_STORE_EN
            rd_addr = 4'($urandom_range(0, 10));
            #1 check("store_rand", rd_key, exp_rk[rd_addr]);
            @(negedge clk);
`endif
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                check_zero_ignore_hold();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    task automatic check_zero_ignore_hold();
        check("gap_busy", 128'(busy), 128'(0));
        check("gap_rk_valid", 128'(rk_valid), 128'(0));
        check("gap_rk_hold", rk_out, exp_rk[0]);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
